// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// State encodings, forward-select codes, register-address width.
package pipeline_ctrl_pkg;

  localparam int DEF_REG_AW = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM_WB  = 2'b01,
    FWD_EX_MEM  = 2'b10
  } fwd_sel_t;

  function automatic logic is_adv_state(
    input state_t s
  );
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Sequencer <-> core/debug bundle.
// master = sequencer side, slave = core/debug side.
interface pipeline_sequencer_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              i_dbg_run;
  logic              i_dbg_step;
  logic              i_dbg_pause;
  logic              i_dbg_clear;
  logic              i_ID_EX_mem_read;
  logic [REG_AW-1:0] i_ID_EX_rd;
  logic [REG_AW-1:0] i_IF_ID_rs1;
  logic [REG_AW-1:0] i_IF_ID_rs2;
  logic              i_IF_ID_uses_rs2;
  logic              i_branch_taken;
  logic              i_WB_halt;
  logic              o_pipe_en;
  logic              o_pc_write;
  logic              o_IF_ID_write;
  logic              o_IF_ID_flush;
  logic              o_ID_EX_flush;
  logic              o_halted;
  logic [CNT_W-1:0]  o_cycle_cnt;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport master (
    input  i_dbg_run, i_dbg_step,
    input  i_dbg_pause, i_dbg_clear,
    input  i_ID_EX_mem_read, i_ID_EX_rd,
    input  i_IF_ID_rs1, i_IF_ID_rs2,
    input  i_IF_ID_uses_rs2,
    input  i_branch_taken, i_WB_halt,
    output o_pipe_en, o_pc_write,
    output o_IF_ID_write, o_IF_ID_flush,
    output o_ID_EX_flush, o_halted,
    output o_cycle_cnt, o_stall_cnt
  );

  modport slave (
    output i_dbg_run, i_dbg_step,
    output i_dbg_pause, i_dbg_clear,
    output i_ID_EX_mem_read, i_ID_EX_rd,
    output i_IF_ID_rs1, i_IF_ID_rs2,
    output i_IF_ID_uses_rs2,
    output i_branch_taken, i_WB_halt,
    input  o_pipe_en, o_pc_write,
    input  o_IF_ID_write, o_IF_ID_flush,
    input  o_ID_EX_flush, o_halted,
    input  o_cycle_cnt, o_stall_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline advance sequencer: debug run/step/freeze,
// load-use stalls, branch flushes, cycle/stall counters.
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  pipeline_sequencer_if.master bus
);

  state_t state_q;
  state_t state_d;

  logic adv;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic adv_br;
  logic adv_lu;
  logic adv_ok;
  logic cnt_clr;

  logic pipe_en;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_flush;

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_dbg_clear) begin
          state_d = S_IDLE;
        end else if (bus.i_dbg_run) begin
          state_d = S_RUN;
        end else if (bus.i_dbg_step) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (bus.i_WB_halt) begin
          state_d = S_HALTED;
        end else if (bus.i_dbg_pause) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (bus.i_WB_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        if (bus.i_dbg_clear) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A halt in WB freezes the whole pipe for that cycle.
  assign adv = is_adv_state(state_q) & ~bus.i_WB_halt;

  assign rs1_hit = (bus.i_ID_EX_rd == bus.i_IF_ID_rs1);
  assign rs2_hit = bus.i_IF_ID_uses_rs2 &
                   (bus.i_ID_EX_rd == bus.i_IF_ID_rs2);
  assign load_use = bus.i_ID_EX_mem_read &
                    (bus.i_ID_EX_rd != '0) &
                    (rs1_hit | rs2_hit);

  assign adv_br = adv & bus.i_branch_taken;
  assign adv_lu = adv & ~bus.i_branch_taken & load_use;
  assign adv_ok = adv & ~bus.i_branch_taken & ~load_use;

  always_comb begin
    pipe_en     = 1'b0;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (1'b1)
      adv_br: begin
        pipe_en     = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      adv_lu: begin
        pipe_en     = 1'b1;
        id_ex_flush = 1'b1;
      end
      adv_ok: begin
        pipe_en     = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign cnt_clr = bus.i_dbg_clear &
                   ((state_q == S_IDLE) | (state_q == S_HALTED));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (adv),
    .i_clr     (cnt_clr),
    .o_cnt     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_inc     (adv_lu),
    .i_clr     (cnt_clr),
    .o_cnt     (stall_cnt)
  );

  assign bus.o_pipe_en     = pipe_en;
  assign bus.o_pc_write    = pc_write;
  assign bus.o_IF_ID_write = if_id_write;
  assign bus.o_IF_ID_flush = if_id_flush;
  assign bus.o_ID_EX_flush = id_ex_flush;
  assign bus.o_halted      = (state_q == S_HALTED);
  assign bus.o_cycle_cnt   = cycle_cnt;
  assign bus.o_stall_cnt   = stall_cnt;

endmodule
